alu_exec_unit: RTL
==================

# alu_exec_unit

Parametrised execute-stage successor to the combinational ALU control decoder. Accepts one operation per handshake, decodes `alu_op`/`funct3`/`funct7` into a full RV32I-class ALU op set (adds XOR, shifts, SLTU, I-type decode), and registers the result. Optionally adds iterative RV-M multiply/divide behind a busy/ready handshake. Sits between the register-read stage and writeback in the multi-cycle core.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; must be a power of two, ≥8.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit can accept; transfer when `in_valid && in_ready`.
- `alu_op`  in  2  00 ADD, 01 SUB, 10 R-type decode, 11 I-type decode.
- `funct3`  in  3  instruction funct3.
- `funct7`  in  7  instruction funct7 (full field).
- `a`, `b`  in  XLEN  operands (`b` = immediate for I-type).
- `out_valid`  out  1  `result` valid.
- `out_ready`  in  1  consumer takes result; transfer when both high.
- `result`  out  XLEN  registered result.
- `zero`  out  1  `result == 0`, combinational from `result`.
- `illegal`  out  1  registered; qualifies `result` (which is 0 when set).

## Operation
- Decode, `alu_op`=10: funct3 000 ADD/SUB (funct7 0000000/0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (0000000/0100000), 110 OR, 111 AND. Other funct7 illegal, except 0000001 (see Configuration).
- `alu_op`=11: same funct3 map, no SUB; funct7 ignored except 001 needs 0000000, 101 needs 0000000 (SRLI) or 0100000 (SRAI), else illegal.
- Shift amount = `b[$clog2(XLEN)-1:0]`. SLT signed, SLTU unsigned; result zero-extended 0/1. Add/sub wrap modulo 2^XLEN.
- FSM: IDLE, MUL, DIV. ALU ops, illegal ops and div special cases complete from IDLE without leaving it.
- `in_ready` = `!rst && state==IDLE && (!out_valid || out_ready)`.
- `out_valid`/`result`/`illegal` hold stable until consumed; a new result may load in the same cycle the old one is consumed.

## Timing
- Reset: `out_valid`=0, `result`=0, `illegal`=0, `zero`=1, state IDLE, `in_ready`=0 during reset cycle. Reset mid-MUL/DIV aborts; no result produced.
- ALU/illegal: accept at edge N → `out_valid` at N+1 (latency 1, throughput 1/cycle with `out_ready` high).
- MUL family (MUL, MULH, MULHSU, MULHU): sign-magnitude of operands latched at accept, XLEN shift-add iterations in MUL, sign fix on final; `out_valid` at N+XLEN+1. MUL low half; MULH* high half.
- DIV family (DIV, DIVU, REM, REMU): restoring, XLEN iterations, same latency XLEN+1; quotient sign = a^b sign, remainder sign = a sign.
- Div by zero: quotient all-ones, remainder = `a`; signed overflow (min / −1): quotient = min, remainder 0. Both latency 1, no DIV state.
- Inputs ignored while `in_ready`=0; operands latched only at accept.

## Configuration
- `ALU_EXEC_MULDIV_EN` defined: funct7 0000001 with `alu_op`=10 decodes MUL/DIV per funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU); MUL/DIV states and datapath present.
- Not defined: funct7 0000001 is illegal (latency 1, `result`=0, `illegal`=1); no MUL/DIV states or iterative hardware synthesised.

## Test plan
- Reset then R-type SUB, a=5, b=7 → next cycle `out_valid`=1, result=0xFFFF_FFFE, `zero`=0.
- I-type SRAI funct7=0100000, a=0x8000_0000, b=4 → 0xF800_0000; SRLI → 0x0800_0000; I-type funct3=001 funct7=0100000 → `illegal`=1, result 0.
- Back-to-back ADDs with `out_ready` low for 3 cycles → `in_ready`=0, first result held; releases in order, no loss.
- (MULDIV) MULH a=−2, b=3 → out_valid exactly 33 cycles after accept, result=0xFFFF_FFFF; MUL same operands → 0xFFFF_FFFA.
- (MULDIV) DIV a=7, b=0 → 0xFFFF_FFFF in 1 cycle; REM a=0x8000_0000, b=−1 → 0; DIVU 100/7 → 14 after 33 cycles.
- `rst` asserted in cycle 10 of a DIV → next cycle `out_valid`=0, `result`=0, `in_ready`=1 after release, no stale result.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered RV32I-class execute stage with valid/ready handshake.
// Define ALU_EXEC_MULDIV_EN to add iterative RV-M multiply/divide.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SH = $clog2(XLEN);
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_ILL, OP_MD
    } op_e;

    op_e             dec_op;
    logic [SH-1:0]   shamt;
    logic            lt_s;
    logic            lt_u;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] fast_res;
    logic            fast_ill;
    logic            accept;
    logic            busy;
    logic            md_start;
    logic            md_done;
    logic [XLEN-1:0] md_res;

    function automatic op_e base_op(input logic [2:0] f3);
        unique case (f3)
            3'b000: base_op = OP_ADD;
            3'b001: base_op = OP_SLL;
            3'b010: base_op = OP_SLT;
            3'b011: base_op = OP_SLTU;
            3'b100: base_op = OP_XOR;
            3'b101: base_op = OP_SRL;
            3'b110: base_op = OP_OR;
            3'b111: base_op = OP_AND;
        endcase
    endfunction

    always_comb begin
        dec_op = OP_ILL;
        unique case (alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                unique case (1'b1)
                    (funct7 == F7_BASE): dec_op = base_op(funct3);
                    (funct7 == F7_ALT): begin
                        if (funct3 == 3'b000)      dec_op = OP_SUB;
                        else if (funct3 == 3'b101) dec_op = OP_SRA;
                        else                       dec_op = OP_ILL;
                    end
`ifdef ALU_EXEC_MULDIV_EN
                    (funct7 == 7'b0000001): dec_op = OP_MD;
`endif
                    default: dec_op = OP_ILL;
                endcase
            end
            default: begin
                // I-type: funct7 only matters for the shift encodings
                dec_op = base_op(funct3);
                if (funct3 == 3'b001 && funct7 != F7_BASE)
                    dec_op = OP_ILL;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       dec_op = OP_SRA;
                    else if (funct7 != F7_BASE) dec_op = OP_ILL;
                end
            end
        endcase
    end

    assign shamt = b[SH-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        alu_res = '0;
        unique case (dec_op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLL:  alu_res = a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            OP_XOR:  alu_res = a ^ b;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            default: alu_res = '0;
        endcase
    end

    assign fast_ill = (dec_op == OP_ILL);
    assign in_ready = !rst && !busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_EXEC_MULDIV_EN
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SH:0] CNT_LAST = {1'b1, {SH{1'b0}}};
    localparam logic [SH:0] CNT_ONE  = {{SH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e            state_q, state_d;
    logic [SH:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        f3_q, f3_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              a_sgn, b_sgn;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, md_fast;
    logic [XLEN-1:0]   md_fast_res;
    logic [XLEN:0]     sum, trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (funct3)
            3'b001:         begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'b010:         a_sgn = 1'b1;
            3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            default:        ;
        endcase
    end

    assign a_neg = a_sgn && a[XLEN-1];
    assign b_neg = b_sgn && b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // divide corner cases bypass the iterative unit
    assign div_zero = funct3[2] && (b == '0);
    assign div_ovf  = (funct3 == 3'b100 || funct3 == 3'b110)
                   && (a == SMIN) && (&b);
    assign md_fast  = div_zero || div_ovf;
    assign md_fast_res = div_zero ? (funct3[1] ? a : '1)
                                  : (funct3[1] ? '0 : SMIN);

    assign busy     = (state_q != S_IDLE);
    assign md_start = accept && (dec_op == OP_MD) && !md_fast;
    assign fast_res = (dec_op == OP_MD) ? md_fast_res : alu_res;

    assign sum   = {1'b0, hi_q} + {1'b0, opnd_q & {XLEN{lo_q[0]}}};
    assign trial = {hi_q, lo_q[XLEN-1]} - {1'b0, opnd_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        f3_d    = f3_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        md_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (md_start) begin
                    state_d = funct3[2] ? S_DIV : S_MUL;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = funct3[2] ? a_mag : b_mag;
                    opnd_d  = funct3[2] ? b_mag : a_mag;
                    f3_d    = funct3;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    md_done = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DIV: begin
                if (cnt_q == CNT_LAST) begin
                    md_done = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (!trial[XLEN]) begin
                        hi_d = trial[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        md_res   = '0;
        prod_fix = qneg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_fix  = qneg_q ? -lo_q : lo_q;
        rem_fix  = rneg_q ? -hi_q : hi_q;
        if (state_q == S_DIV)
            md_res = f3_q[1] ? rem_fix : quo_fix;
        else if (f3_q == 3'b000)
            md_res = prod_fix[XLEN-1:0];
        else
            md_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            f3_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            f3_q    <= f3_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
`else
    assign busy     = 1'b0;
    assign md_start = 1'b0;
    assign md_done  = 1'b0;
    assign md_res   = '0;
    assign fast_res = alu_res;
`endif

    // a new result may replace the one being consumed in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            illegal   <= 1'b0;
        end else if (accept && !md_start) begin
            out_valid <= 1'b1;
            result    <= fast_ill ? '0 : fast_res;
            illegal   <= fast_ill;
        end else if (md_done) begin
            out_valid <= 1'b1;
            result    <= md_res;
            illegal   <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign zero = (result == '0);

endmodule
